// File: rtl/fetch_queue_if.sv
//------------------------------------------------------------------------------
// Module      : fetch_queue_if
// Description : Bundle of instruction-memory, redirect, stall and decode-side
//               signals of the prefetch queue. The master modport is the fetch
//               queue itself; the slave modport is the surrounding pipeline and
//               instruction memory.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_incremented_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_data,
        input  branch_taken,
        input  branch_target,
        input  stall,
        output out_valid,
        output out_instruction,
        output out_incremented_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_data,
        output branch_taken,
        output branch_target,
        output stall,
        input  out_valid,
        input  out_instruction,
        input  out_incremented_pc
    );
endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// Module      : fetch_queue
// Description : Instruction prefetch queue. Issues one fetch per cycle while
//               the queue has credit (queued entries + outstanding request
//               below DEPTH), captures the instruction word the cycle after
//               each request and presents the queue head to decode. A taken
//               branch flushes the queue, drops the outstanding response and
//               redirects the PC to the word-aligned target.
//               DEPTH must be a power of two in the range 2..16.
//               Optional feature macro FETCH_QUEUE_STATS_EN adds the 16-bit
//               saturating stall_cycles counter output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fetch_queue_if.master     fq
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output      logic [15:0]  stall_cycles
`endif
);

    localparam int                 c_ptr_w     = $clog2(DEPTH);
    localparam int                 c_cnt_w     = c_ptr_w + 1;
    localparam logic [c_cnt_w:0]   c_depth     = DEPTH[c_cnt_w:0];
    localparam logic [c_ptr_w-1:0] c_ptr_one   = 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one   = 1;
    localparam logic [31:0]        c_word_step = 32'd4;

    // Fetch side state
    logic [31:0]        r_pc;
    logic [31:0]        r_fetch_addr;
    logic               r_inflight;

    // Queue storage and bookkeeping
    logic [31:0]        r_instr_mem [DEPTH];
    logic [31:0]        r_ipc_mem   [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic [c_cnt_w:0]   w_occupancy;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;
    logic               w_unused_tgt_lsbs;

    // The outstanding request reserves a slot so the response can never
    // arrive at a full queue.
    assign w_occupancy = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight};
    assign w_req       = !reset && !fq.branch_taken && (w_occupancy < c_depth);

    // A redirect kills both the arriving response and the pop of the head.
    assign w_valid = (r_count != '0);
    assign w_push  = r_inflight && !fq.branch_taken;
    assign w_pop   = w_valid && !fq.stall && !fq.branch_taken;

    // Redirect targets are forced to word alignment, so the low bits are dropped.
    assign w_unused_tgt_lsbs = &{1'b0, fq.branch_target[1:0]};

    assign fq.imem_req           = w_req;
    assign fq.imem_addr          = r_pc;
    assign fq.out_valid          = w_valid;
    assign fq.out_instruction    = w_valid ? r_instr_mem[r_rd_ptr] : 32'd0;
    assign fq.out_incremented_pc = w_valid ? r_ipc_mem[r_rd_ptr]   : 32'd0;

    // PC, outstanding-request tracking and queue pointers/occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_fetch_addr <= 32'd0;
            r_inflight   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else if (fq.branch_taken) begin
            r_pc       <= {fq.branch_target[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_req) begin
                r_pc         <= r_pc + c_word_step;
                r_fetch_addr <= r_pc;
            end
            r_inflight <= w_req;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue payload: the returned word and the address of the following instruction.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= fq.imem_data;
            r_ipc_mem[r_wr_ptr]   <= r_fetch_addr + c_word_step;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] r_stall_cycles;

    // Count edges where decode holds a valid head; saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= 16'd0;
        end else if (w_valid && fq.stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A reference model tracks
//               PC, the outstanding fetch and the expected queue contents as a
//               plain queue; a monitor compares the decode-side outputs and the
//               fetch requests against it every cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    fetch_queue_if fq ();

`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] stall_cycles;
`endif

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fq           (fq)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] ipc;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_addr;
    bit          plan_valid;
    bit          p_branch;
    logic [31:0] p_tgt;
    bit          exp_req;
    int          n_checks;
    int          n_fail;

    // Instruction memory contents: a scrambled function of the address.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply the effect of the clock edge that just passed to the model.
    task automatic commit();
        if (!plan_valid) return;
        if (p_branch) begin
            exp_q.delete();
            m_pend = 1'b0;
            m_pc   = {p_tgt[31:2], 2'b00};
        end else begin
            if (m_pend) begin
                ent_t e;
                e.ins = pat(m_pend_addr);
                e.ipc = m_pend_addr + 32'd4;
                exp_q.push_back(e);
            end
            m_pend = exp_req;
            if (exp_req) begin
                m_pend_addr = m_pc;
                m_pc        = m_pc + 32'd4;
            end
        end
    endtask

    // One cycle of stimulus: inputs change on the falling edge.
    task automatic step(input bit s, input bit b, input logic [31:0] t);
        @(negedge clk);
        commit();
        reset            = 1'b0;
        fq.stall         = s;
        fq.branch_taken  = b;
        fq.branch_target = t;
        fq.imem_data     = m_pend ? pat(m_pend_addr) : $urandom();
        exp_req          = !b && ((exp_q.size() + int'(m_pend)) < DEPTH);
        p_branch         = b;
        p_tgt            = t;
        plan_valid       = 1'b1;
    endtask

    // Asynchronous reset assertion away from any clock edge, then hold.
    task automatic do_reset(input int cyc);
        reset = 1'b1;
        #1;
        chk("rst_imem_req", fq.imem_req, 32'd0);
        chk("rst_imem_addr", fq.imem_addr, RESET_PC);
        chk("rst_out_valid", fq.out_valid, 32'd0);
        chk("rst_out_instruction", fq.out_instruction, 32'd0);
        chk("rst_out_incremented_pc", fq.out_incremented_pc, 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
        chk("rst_stall_cycles", stall_cycles, 32'd0);
`endif
        plan_valid = 1'b0;
        exp_q.delete();
        m_pc   = RESET_PC;
        m_pend = 1'b0;
        repeat (cyc) @(negedge clk);
    endtask

    // Monitor: compare requests and the presented head against the model.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            chk("hold_imem_req", fq.imem_req, 32'd0);
            chk("hold_out_valid", fq.out_valid, 32'd0);
            chk("hold_out_instruction", fq.out_instruction, 32'd0);
            chk("hold_out_incremented_pc", fq.out_incremented_pc, 32'd0);
        end else if (plan_valid) begin
            chk("imem_req", fq.imem_req, {31'd0, exp_req});
            if (exp_req) chk("imem_addr", fq.imem_addr, m_pc);
            chk("out_valid", fq.out_valid, {31'd0, exp_q.size() != 0});
            if (fq.out_valid && exp_q.size() != 0) begin
                chk("out_instruction", fq.out_instruction, exp_q[0].ins);
                chk("out_incremented_pc", fq.out_incremented_pc, exp_q[0].ipc);
                if (!fq.stall && !fq.branch_taken) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        plan_valid       = 1'b0;
        m_pc             = RESET_PC;
        m_pend           = 1'b0;
        m_pend_addr      = 32'd0;
        p_branch         = 1'b0;
        p_tgt            = 32'd0;
        exp_req          = 1'b0;
        fq.stall         = 1'b0;
        fq.branch_taken  = 1'b0;
        fq.branch_target = 32'd0;
        fq.imem_data     = 32'd0;

        @(negedge clk);
        #3;
        do_reset(2);

        // Streaming from reset: one address per cycle, head two cycles behind.
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 32'd0);
            #3;
            chk("stream_addr", fq.imem_addr, 32'(4 * k));
            chk("stream_valid", fq.out_valid, {31'd0, k >= 2});
            if (k >= 2) chk("stream_ipc", fq.out_incremented_pc, 32'(4 * (k - 1)));
        end

        // Long stall: queue fills, requests stop, head is held.
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 32'd0);
        #3;
        chk("full_imem_req", fq.imem_req, 32'd0);
        chk("full_out_valid", fq.out_valid, 32'd1);
        chk("full_head_ipc", fq.out_incremented_pc, 32'd44);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'd0);

        // Redirect to a misaligned target with entries queued.
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h0000_0103);
        step(1'b0, 1'b0, 32'd0);
        #3;
        chk("redir_valid", fq.out_valid, 32'd0);
        chk("redir_addr", fq.imem_addr, 32'h0000_0100);
        chk("redir_req", fq.imem_req, 32'd1);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        #3;
        chk("redir_first_valid", fq.out_valid, 32'd1);
        chk("redir_first_ipc", fq.out_incremented_pc, 32'h0000_0104);

        // Redirect coincident with push+pop, then with push under stall.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h0000_2000);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_3000);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'd0);

        // Address wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFA);
        step(1'b0, 1'b0, 32'd0);
        #3;
        chk("wrap_addr0", fq.imem_addr, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 32'd0);
        #3;
        chk("wrap_addr1", fq.imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0);
        #3;
        chk("wrap_addr2", fq.imem_addr, 32'h0000_0000);
        chk("wrap_ipc0", fq.out_incremented_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0);
        #3;
        chk("wrap_ipc1", fq.out_incremented_pc, 32'h0000_0000);

        // Random traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                step(1'b0, 1'b0, 32'd0);
                #3;
                do_reset(2);
            end else begin
                step(($urandom() % 3) == 0, ($urandom() % 16) == 0, $urandom());
            end
        end

`ifdef FETCH_QUEUE_STATS_EN
        step(1'b0, 1'b0, 32'd0);
        #3;
        do_reset(2);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        #3;
        chk("stall_cycles", stall_cycles, 32'd5);
        do_reset(1);
`endif

        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
